// File: rtl/rll_pkg.sv
// rll_pkg: shared types and constants for the RLL(2,7) transmit path.
//   rll_state_e      : frame sequencer states
//   RLL_PREAMBLE_DEF : default sync pattern (sent MSB first)
//   RLL_TAIL_MIN     : minimum number of zero flush bits
//   RLL_MAX_GROUP    : longest RLL(2,7) input group, in bits
// The encoder imports RLL_TAIL_MIN and RLL_MAX_GROUP as well.
package rll_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    LOAD = 3'd2,
    DATA = 3'd3,
    TAIL = 3'd4,
    DONE = 3'd5
  } rll_state_e;

  localparam logic [7:0] RLL_PREAMBLE_DEF = 8'hA5;
  localparam int         RLL_TAIL_MIN     = 4;
  localparam int         RLL_MAX_GROUP    = 4;

endpackage

// File: rtl/rll_piso.sv
// rll_piso: 8-bit parallel-load, MSB-first shift register with a valid/ready
// serial output. It carries the preamble, the payload bytes and the zero tail.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_load       : load i_data/i_cnt; takes priority over a shift in the same cycle
//   i_data       : left-aligned bits to send (bit 7 goes out first)
//   i_cnt        : number of bits to send minus one
//   i_ready      : sink accepts o_bit this cycle
//   o_bit        : current serial bit (held while o_valid && !i_ready)
//   o_valid      : o_bit is valid
//   o_last       : the bit currently presented is the last one of the load
module rll_piso (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic [2:0] i_cnt,
  input  logic       i_ready,
  output logic       o_bit,
  output logic       o_valid,
  output logic       o_last
);

  logic [7:0] r_sh;
  logic [2:0] r_cnt;
  logic       r_vld;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= i_cnt;
      r_vld <= 1'b1;
    end else if (r_vld && i_ready) begin
      // Always shift in zeros so the line idles low once the load is drained.
      r_sh <= {r_sh[6:0], 1'b0};
      if (r_cnt == 3'd0) r_vld <= 1'b0;
      else               r_cnt <= r_cnt - 3'd1;
    end
  end

  assign o_bit   = r_sh[7];
  assign o_valid = r_vld;
  assign o_last  = (r_cnt == 3'd0);

endmodule

// File: rtl/rll_tx_frame_ctrl.sv
// rll_tx_frame_ctrl: frame sequencer feeding the RLL(2,7) encoder.
// On start it streams preamble, len payload bytes and a zero flush tail as a
// bit-serial valid/ready stream.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i, len_i        : begin frame with len_i payload bytes (IDLE only)
//   byte_i, byte_valid_i  : upstream payload byte source
//   byte_ready_o          : byte accepted this cycle (LOAD state)
//   enc_bit_o/_valid_o    : serial bit stream to the encoder
//   enc_bit_ready_i       : encoder consumes the bit this cycle
//   enc_flush_o           : tail bits are being presented
//   busy_o, done_o        : frame in progress / one-cycle end-of-frame pulse
// PRE_BITS must be 1..8 and TAIL_BITS RLL_TAIL_MIN..8 (3-bit bit counter).
module rll_tx_frame_ctrl
  import rll_pkg::*;
#(
  parameter int         LEN_W     = 8,
  parameter logic [7:0] PREAMBLE  = RLL_PREAMBLE_DEF,
  parameter int         PRE_BITS  = 8,
  parameter int         TAIL_BITS = RLL_TAIL_MIN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             enc_bit_o,
  output logic             enc_bit_valid_o,
  input  logic             enc_bit_ready_i,
  output logic             enc_flush_o,
  output logic             busy_o,
  output logic             done_o
);

  // Preamble is left-aligned so its MSB leaves the shifter first.
  localparam logic [7:0] PRE_ALIGNED = PREAMBLE << (8 - PRE_BITS);
  localparam logic [2:0] PRE_CNT     = 3'(PRE_BITS - 1);
  localparam logic [2:0] TAIL_CNT    = 3'(TAIL_BITS - 1);

  rll_state_e       r_state, w_state_nxt;
  logic [LEN_W-1:0] r_rem_cnt;
  logic             r_byte_ready, r_flush, r_busy, r_done;

  logic       w_load;
  logic [7:0] w_load_data;
  logic [2:0] w_load_cnt;
  logic       w_piso_bit, w_piso_valid, w_piso_last;
  logic       w_xfer_last;

  assign w_xfer_last = w_piso_valid && enc_bit_ready_i && w_piso_last;

  // Each field's first bit is loaded on the same edge as the previous field's
  // last transfer, so valid stays high across PRE->TAIL and DATA->TAIL.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_cnt  = '0;
    case (r_state)
      IDLE: if (start_i) begin
        w_state_nxt = PRE;
        w_load      = 1'b1;
        w_load_data = PRE_ALIGNED;
        w_load_cnt  = PRE_CNT;
      end
      PRE: if (w_xfer_last) begin
        if (r_rem_cnt == '0) begin
          w_state_nxt = TAIL;
          w_load      = 1'b1;
          w_load_cnt  = TAIL_CNT;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: if (r_byte_ready && byte_valid_i) begin
        w_state_nxt = DATA;
        w_load      = 1'b1;
        w_load_data = byte_i;
        w_load_cnt  = 3'd7;
      end
      DATA: if (w_xfer_last) begin
        // rem_cnt reaches 0 on this transfer when it is currently 1.
        if (r_rem_cnt == LEN_W'(1)) begin
          w_state_nxt = TAIL;
          w_load      = 1'b1;
          w_load_cnt  = TAIL_CNT;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      TAIL: if (w_xfer_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state so they line up
  // with the state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_rem_cnt    <= '0;
      r_byte_ready <= 1'b0;
      r_flush      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_ready <= (w_state_nxt == LOAD);
      r_flush      <= (w_state_nxt == TAIL);
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= (w_state_nxt == DONE);
      if (r_state == IDLE && start_i)
        r_rem_cnt <= len_i;
      else if (r_state == DATA && w_xfer_last && r_rem_cnt != '0)
        r_rem_cnt <= r_rem_cnt - LEN_W'(1);
    end
  end

  rll_piso u_piso (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_cnt   (w_load_cnt),
    .i_ready (enc_bit_ready_i),
    .o_bit   (w_piso_bit),
    .o_valid (w_piso_valid),
    .o_last  (w_piso_last)
  );

  assign enc_bit_o       = w_piso_bit;
  assign enc_bit_valid_o = w_piso_valid;
  assign enc_flush_o     = r_flush;
  assign byte_ready_o    = r_byte_ready;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

endmodule

// File: tb/tb_rll_tx_frame_ctrl.sv
// Bench for rll_tx_frame_ctrl: expected {bit, flush} pairs are queued when a
// frame is set up and popped on every bit handshake.
module tb_rll_tx_frame_ctrl;

  localparam int LEN_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i, start_i;
  logic [LEN_W-1:0] len_i;
  logic [7:0]       byte_i;
  logic             byte_valid_i, byte_ready_o;
  logic             enc_bit_o, enc_bit_valid_o, enc_bit_ready_i;
  logic             enc_flush_o, busy_o, done_o;

  rll_tx_frame_ctrl #(.LEN_W(LEN_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .len_i           (len_i),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid_i),
    .byte_ready_o    (byte_ready_o),
    .enc_bit_o       (enc_bit_o),
    .enc_bit_valid_o (enc_bit_valid_o),
    .enc_bit_ready_i (enc_bit_ready_i),
    .enc_flush_o     (enc_flush_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  int checks = 0, failures = 0;
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  logic [1:0] sb[$];        // {bit, flush}
  logic [7:0] feed_q[$];
  logic [7:0] pay [3];
  logic [7:0] pre_pat = 8'hA5;
  logic       feed_hs = 1'b0, tog_mode = 1'b0;
  int         stall_cfg = 0, stall_left = 0;
  int         n_xfer = 0, n_bready = 0, n_done = 0;
  logic       hold_pend = 1'b0, prev_bit = 1'b0, prev_flush = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Upstream byte source and encoder ready, driven just after each edge.
  always @(posedge clk) begin
    #1;
    if (feed_hs) begin
      if (feed_q.size() > 0) void'(feed_q.pop_front());
      feed_hs    = 1'b0;
      stall_left = stall_cfg;
    end
    byte_valid_i = (feed_q.size() > 0) && (stall_left == 0);
    byte_i       = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    if (byte_ready_o && stall_left > 0) stall_left--;
    enc_bit_ready_i = tog_mode ? ~enc_bit_ready_i : 1'b1;
  end

  // Monitor, sampling mid-cycle.
  always @(negedge clk) begin
    logic [1:0] e;
    if (hold_pend) begin
      checks++;
      assert (enc_bit_valid_o === 1'b1 && enc_bit_o === prev_bit && enc_flush_o === prev_flush) else begin
        failures++;
        $error("FAIL hold_stable: observed v=%b b=%b f=%b expected v=1 b=%b f=%b",
               enc_bit_valid_o, enc_bit_o, enc_flush_o, prev_bit, prev_flush);
      end
    end
    if (byte_ready_o === 1'b1) begin
      n_bready++;
      chk("load_valid_low", enc_bit_valid_o, 0);
      if (byte_valid_i) feed_hs = 1'b1;
    end
    if (enc_flush_o === 1'b1) chk("flush_implies_valid", enc_bit_valid_o, 1);
    if (done_o === 1'b1) n_done++;
    if (enc_bit_valid_o === 1'b1 && enc_bit_ready_i && !rst_i) begin
      n_xfer++;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_extra_bit: observed bit=%b with empty queue, expected no transfer", enc_bit_o);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_bit_flush", {enc_bit_o, enc_flush_o}, e);
      end
    end
    hold_pend  = enc_bit_valid_o && !enc_bit_ready_i && !rst_i;
    prev_bit   = enc_bit_o;
    prev_flush = enc_flush_o;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic setup_frame(input int len);
    n_xfer = 0; n_bready = 0; n_done = 0; stall_left = stall_cfg;
    for (int i = 7; i >= 0; i--) sb.push_back({pre_pat[i], 1'b0});
    for (int k = 0; k < len; k++) begin
      feed_q.push_back(pay[k]);
      for (int i = 7; i >= 0; i--) sb.push_back({pay[k][i], 1'b0});
    end
    repeat (4) sb.push_back(2'b01);
  endtask

  task automatic pulse_start(input int len, output int e);
    len_i = LEN_W'(len); start_i = 1'b1;
    step();
    e = edges; start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at_edge);
    bit got = 0;
    at_edge = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin got = 1; at_edge = edges; end
    end
    checks++;
    assert (got) else begin
      failures++;
      $error("FAIL done_timeout: observed no done_o in %0d cycles, expected a pulse", budget);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_bready"}, byte_ready_o, 0);
    chk({tag, "_valid"}, enc_bit_valid_o, 0);
    chk({tag, "_bit"}, enc_bit_o, 0);
    chk({tag, "_flush"}, enc_flush_o, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, d;
    rst_i = 1'b1; start_i = 1'b0; len_i = '0;
    enc_bit_ready_i = 1'b1; byte_valid_i = 1'b0; byte_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    step(); rst_i = 1'b0;

    // 1: len=1, byte 0x3C held valid
    pay[0] = 8'h3C;
    setup_frame(1);
    step();
    pulse_start(1, e);
    wait_done(100, d);
    chk("t1_done_latency", d - e, 21);
    chk("t1_bready_cycles", n_bready, 1);
    chk("t1_xfers", n_xfer, 20);
    chk("t1_sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done_o, 0);
    chk("t1_done_count", n_done, 1);

    // 2: len=0, preamble and tail only
    setup_frame(0);
    step();
    pulse_start(0, e);
    wait_done(100, d);
    chk("t2_done_latency", d - e, 12);
    chk("t2_xfers", n_xfer, 12);
    chk("t2_bready_never", n_bready, 0);
    @(negedge clk);
    chk("t2_busy_low_after", busy_o, 0);
    chk("t2_sb_empty", sb.size(), 0);

    // 3: len=2, ready toggling every cycle
    pay[0] = 8'hFF; pay[1] = 8'h81;
    tog_mode = 1'b1;
    setup_frame(2);
    step();
    pulse_start(2, e);
    wait_done(300, d);
    chk("t3_xfers", n_xfer, 28);
    chk("t3_sb_empty", sb.size(), 0);
    tog_mode = 1'b0;
    step();

    // 4: len=3, byte_valid withheld 5 cycles in each LOAD
    pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'h56;
    stall_cfg = 5;
    setup_frame(3);
    step();
    pulse_start(3, e);
    wait_done(300, d);
    chk("t4_done_latency", d - e, 54);
    chk("t4_xfers", n_xfer, 36);
    chk("t4_bready_cycles", n_bready, 18);
    chk("t4_sb_empty", sb.size(), 0);
    stall_cfg = 0;
    step();

    // 5: start during DATA and in DONE ignored, start right after DONE accepted
    pay[0] = 8'hA0; pay[1] = 8'h0F;
    setup_frame(2);
    step();
    pulse_start(2, e);
    repeat (11) step();
    start_i = 1'b1; len_i = LEN_W'(7);
    step();
    start_i = 1'b0;
    wait_done(300, d);
    chk("t5_done_latency", d - e, 30);
    chk("t5_xfers", n_xfer, 28);
    chk("t5_sb_empty", sb.size(), 0);
    // Still in the DONE cycle: hold start high through the following IDLE cycle.
    pay[0] = 8'hC3;
    setup_frame(1);
    start_i = 1'b1; len_i = LEN_W'(1);
    @(negedge clk);
    chk("t5_done_start_ignored", busy_o, 0);
    step();
    e = edges; start_i = 1'b0;
    wait_done(100, d);
    chk("t5_restart_latency", d - e, 21);
    chk("t5_restart_sb_empty", sb.size(), 0);
    step();

    // 6: reset during the 4th payload bit, then a clean len=1 frame
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    setup_frame(2);
    step();
    pulse_start(2, e);
    repeat (12) step();
    rst_i = 1'b1;
    step();
    @(negedge clk);
    chk_all_zero("t6_abort");
    sb.delete(); feed_q.delete(); feed_hs = 1'b0;
    step(); rst_i = 1'b0;
    repeat (5) step();
    chk("t6_no_done", n_done, 0);
    chk("t6_idle_busy", busy_o, 0);
    pay[0] = 8'h3C;
    setup_frame(1);
    pulse_start(1, e);
    wait_done(100, d);
    chk("t6_after_latency", d - e, 21);
    chk("t6_after_xfers", n_xfer, 20);
    chk("t6_after_sb_empty", sb.size(), 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
